// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
// Frame format is captured at start-bit detection and held for the whole frame.
module uart_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rts_n
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_nxt;
    logic [1:0] sync;
    logic       rx_s;
    logic [3:0] tick_cnt, tick_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [1:0] cfg_bits, cfg_bits_nxt;
    logic       cfg_stop2, cfg_stop2_nxt;
    logic       cfg_par_en, cfg_par_en_nxt;
    logic       cfg_par_odd, cfg_par_odd_nxt;
    logic       stop_idx, stop_idx_nxt;
    logic       ferr_acc, ferr_nxt;
    logic       perr_acc, perr_nxt;
    logic       frame_end;
    logic [2:0] bit_last;
    logic       mid_bit;

    assign rx_s     = sync[1];
    assign bit_last = {1'b0, cfg_bits} + 3'd4;
    assign mid_bit  = (tick_cnt == 4'd15);
    assign rts_n    = rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift       <= 8'd0;
            cfg_bits    <= 2'd0;
            cfg_stop2   <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            stop_idx    <= 1'b0;
            ferr_acc    <= 1'b0;
            perr_acc    <= 1'b0;
        end else if (tick) begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            cfg_bits    <= cfg_bits_nxt;
            cfg_stop2   <= cfg_stop2_nxt;
            cfg_par_en  <= cfg_par_en_nxt;
            cfg_par_odd <= cfg_par_odd_nxt;
            stop_idx    <= stop_idx_nxt;
            ferr_acc    <= ferr_nxt;
            perr_acc    <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        tick_cnt_nxt    = tick_cnt;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift;
        cfg_bits_nxt    = cfg_bits;
        cfg_stop2_nxt   = cfg_stop2;
        cfg_par_en_nxt  = cfg_par_en;
        cfg_par_odd_nxt = cfg_par_odd;
        stop_idx_nxt    = stop_idx;
        ferr_nxt        = ferr_acc;
        perr_nxt        = perr_acc;
        frame_end       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt       = START;
                    tick_cnt_nxt    = 4'd0;
                    bit_cnt_nxt     = 3'd0;
                    shift_nxt       = 8'd0;
                    cfg_bits_nxt    = data_bit_num;
                    cfg_stop2_nxt   = stop_bit_num;
                    cfg_par_en_nxt  = parity_en;
                    cfg_par_odd_nxt = parity_type;
                    stop_idx_nxt    = 1'b0;
                    ferr_nxt        = 1'b0;
                    perr_nxt        = 1'b0;
                end
            end
            START: begin
                if (tick_cnt == 4'd7) begin
                    tick_cnt_nxt = 4'd0;
                    state_nxt    = rx_s ? IDLE : DATA;
                end else begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shift_nxt[bit_cnt] = rx_s;
                    tick_cnt_nxt       = 4'd0;
                    bit_cnt_nxt        = bit_cnt + 3'd1;
                    if (bit_cnt == bit_last)
                        state_nxt = cfg_par_en ? PARITY : STOP;
                end else begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                end
            end
            PARITY: begin
                // unused upper shift bits are zero, so a full-width XOR covers N bits
                if (mid_bit) begin
                    perr_nxt     = ((^shift) ^ rx_s) != cfg_par_odd;
                    tick_cnt_nxt = 4'd0;
                    state_nxt    = STOP;
                end else begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    ferr_nxt     = ferr_acc | ~rx_s;
                    tick_cnt_nxt = 4'd0;
                    if (cfg_stop2 && !stop_idx) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        frame_end = 1'b1;
                    end
                end else begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            rx_data     <= 8'd0;
            rx_done     <= 1'b0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync    <= {sync[0], rx};
            rx_done <= tick & frame_end;
            if (tick && frame_end) begin
                rx_data     <= shift;
                frame_err   <= ferr_nxt;
                parity_err  <= cfg_par_en & perr_acc;
                // a read landing on the completion edge consumes the old word
                overrun_err <= rx_valid & ~rx_rd;
                rx_valid    <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are built from data/format
// parameters and the expected word and flags are computed from the frame rules.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       rx = 1'b1;
    logic [1:0] data_bit_num = 2'd3;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done, rx_valid, parity_err, frame_err, overrun_err, rts_n;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_wide = 0;
    logic prev_done = 1'b0;
    logic model_valid = 1'b0;
    logic [1:0] div = 2'd0;

    uart_rx dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
        .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_done(rx_done), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .rts_n(rts_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign tick = (div == 2'd3);

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            if (prev_done) done_wide++;
        end
        prev_done = rx_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // returns at the negedge just before a tick-qualified posedge
    task automatic wait_tick();
        do @(negedge clk); while (!tick);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (16) wait_tick();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic do_read();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        model_valid = 1'b0;
        wait_tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_rts"}, rts_n, 0);
        chk({tag, "_errs"}, {parity_err, frame_err, overrun_err}, 0);
        chk({tag, "_done"}, rx_done, 0);
    endtask

    // Drive one frame; rd_at_end strobes rx_rd on the clock where the last stop bit is sampled.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] nb,
                              input logic s2, input logic pen, input logic ptype,
                              input logic pflip, input logic sb0, input logic sb1,
                              input logic rd_at_end);
        int n;
        logic [7:0] exp_d;
        logic pbit, last, exp_ovr;
        int done_before;
        n = 5 + int'(nb);
        exp_d = d & 8'((1 << n) - 1);
        pbit = 1'b0;
        for (int i = 0; i < n; i++) pbit = pbit ^ exp_d[i];
        pbit = pbit ^ ptype ^ pflip;
        done_before = done_cnt;
        data_bit_num = nb; stop_bit_num = s2; parity_en = pen; parity_type = ptype;
        send_bit(1'b0);
        // format pins are scrambled after the start bit; the frame must use the captured format
        data_bit_num = 2'($urandom); stop_bit_num = 1'($urandom);
        parity_en = 1'($urandom); parity_type = 1'($urandom);
        for (int i = 0; i < n; i++) send_bit(exp_d[i]);
        if (pen) send_bit(pbit);
        if (s2) send_bit(sb0);
        last = s2 ? sb1 : sb0;
        rx = last;
        repeat (9) wait_tick();
        if (rd_at_end) rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        repeat (7) wait_tick();
        rx = 1'b1;
        exp_ovr = rd_at_end ? 1'b0 : model_valid;
        model_valid = 1'b1;
        chk({tag, "_done"}, done_cnt - done_before, 1);
        chk({tag, "_data"}, rx_data, exp_d);
        chk({tag, "_perr"}, parity_err, pen & pflip);
        chk({tag, "_ferr"}, frame_err, !sb0 || (s2 && !sb1));
        chk({tag, "_ovr"}, overrun_err, exp_ovr);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_rts"}, rts_n, 1);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_tick();
        idle(20);
        chk("reset_no_done", done_cnt, 0);

        send_frame("8n1_a5", 8'hA5, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(32);
        send_frame("7e1_41", 8'h41, 2'd2, 0, 1, 0, 1, 1, 1, 0);
        idle(32);
        send_frame("5o2_15", 8'h15, 2'd0, 1, 1, 1, 0, 1, 0, 0);
        chk("5o2_upper", rx_data[7:5], 0);
        idle(48);
        do_read();
        chk("read_valid", rx_valid, 0);
        chk("read_rts", rts_n, 0);

        d0 = done_cnt;
        rx = 1'b0;
        repeat (4) wait_tick();
        idle(40);
        chk("glitch_no_done", done_cnt - d0, 0);
        send_frame("after_glitch", 8'h3C, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(32);
        do_read();

        send_frame("b2b_11", 8'h11, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        send_frame("b2b_22", 8'h22, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(8);
        do_read();
        chk("b2b_clear_valid", rx_valid, 0);
        chk("b2b_clear_rts", rts_n, 0);
        idle(16);

        send_frame("coinc_pre", 8'h96, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(16);
        send_frame("coinc_rd", 8'h69, 2'd3, 0, 1, 1, 0, 1, 1, 1);
        idle(16);
        do_read();

        send_frame("pre_rst", 8'hC3, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(16);
        d0 = done_cnt;
        data_bit_num = 2'd3; stop_bit_num = 0; parity_en = 0;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rx = 1'b0;
        repeat (8) wait_tick();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rx = 1'b1;
        rst_n = 1'b1;
        model_valid = 1'b0;
        wait_tick();
        idle(48);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_valid_hold", rx_valid, 0);
        send_frame("after_rst", 8'h5A, 2'd3, 0, 0, 0, 0, 1, 1, 0);
        idle(32);

        for (int k = 0; k < 30; k++) begin
            logic [1:0] nb;
            logic s2, pen, ptype, pflip, sb0, sb1, rde;
            nb = 2'($urandom_range(0, 3));
            s2 = 1'($urandom);
            pen = 1'($urandom);
            ptype = 1'($urandom);
            pflip = pen && ($urandom_range(0, 3) == 0);
            sb0 = ($urandom_range(0, 5) != 0);
            sb1 = ($urandom_range(0, 5) != 0);
            rde = ($urandom_range(0, 5) == 0);
            send_frame($sformatf("rnd%0d", k), 8'($urandom), nb, s2, pen, ptype,
                       pflip, sb0, sb1, rde);
            idle(48);
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                chk($sformatf("rnd%0d_read", k), rx_valid, 0);
            end
        end

        chk("done_single_cycle", done_wide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
